// File: rtl/ofmd_relu_pool.sv
// rtl/ofmd_relu_pool.sv - ReLU followed by 2x2/stride-2 max-pool on a dual-channel OFMD raster stream
module ofmd_relu_pool #(
    parameter int DATA_WIDTH = 16,
    parameter int OFMD_W_3   = 6,
    parameter int OFMD_W_5   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_st,
    input  logic                  is_5x5,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    output logic                  pool_vld,
    output logic [DATA_WIDTH-1:0] pool_dout1,
    output logic [DATA_WIDTH-1:0] pool_dout2,
    output logic                  pool_done
);

    localparam int NMAX = (OFMD_W_3 > OFMD_W_5) ? OFMD_W_3 : OFMD_W_5;
    localparam int CW   = $clog2(NMAX);
    localparam int NB   = NMAX / 2;
    localparam int KW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST3 = CW'(OFMD_W_3 - 1);
    localparam logic [CW-1:0] LAST5 = CW'(OFMD_W_5 - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d, row_q, row_d;
    logic                    mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   pair1_q, pair1_d, pair2_q, pair2_d;
    logic [DATA_WIDTH-1:0]   lbuf1_q [NB];
    logic [DATA_WIDTH-1:0]   lbuf1_d [NB];
    logic [DATA_WIDTH-1:0]   lbuf2_q [NB];
    logic [DATA_WIDTH-1:0]   lbuf2_d [NB];
    logic                    vld_q, vld_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]   dout1_q, dout1_d, dout2_q, dout2_d;

    logic                    eff_mode;
    logic [CW-1:0]           last;
    logic [KW-1:0]           k;
    logic [DATA_WIDTH-1:0]   r1, r2, m1, m2, v1, v2;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        pair1_d = pair1_q;
        pair2_d = pair2_q;
        lbuf1_d = lbuf1_q;
        lbuf2_d = lbuf2_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        dout1_d = dout1_q;
        dout2_d = dout2_q;

        // The first beat of a frame sees is_5x5 directly; afterwards only the latched copy counts.
        eff_mode = (state_q == IDLE) ? is_5x5 : mode_q;
        last     = eff_mode ? LAST5 : LAST3;
        k        = KW'(col_q >> 1);
        r1       = din1[DATA_WIDTH-1] ? '0 : din1;
        r2       = din2[DATA_WIDTH-1] ? '0 : din2;
        m1       = (pair1_q > r1) ? pair1_q : r1;
        m2       = (pair2_q > r2) ? pair2_q : r2;
        v1       = (lbuf1_q[k] > r1) ? lbuf1_q[k] : r1;
        v2       = (lbuf2_q[k] > r2) ? lbuf2_q[k] : r2;

        if (in_st) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                mode_d  = is_5x5;
            end
            if (!col_q[0]) begin
                pair1_d = row_q[0] ? v1 : r1;
                pair2_d = row_q[0] ? v2 : r2;
            end else if (!row_q[0]) begin
                lbuf1_d[k] = m1;
                lbuf2_d[k] = m2;
            end else begin
                vld_d   = 1'b1;
                dout1_d = m1;
                dout2_d = m2;
                done_d  = (row_q == last) && (col_q == last);
            end
            if (col_q == last) begin
                col_d = '0;
                if (row_q == last) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= 1'b0;
            pair1_q <= '0;
            pair2_q <= '0;
            for (int i = 0; i < NB; i++) begin
                lbuf1_q[i] <= '0;
                lbuf2_q[i] <= '0;
            end
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            dout1_q <= '0;
            dout2_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            pair1_q <= pair1_d;
            pair2_q <= pair2_d;
            lbuf1_q <= lbuf1_d;
            lbuf2_q <= lbuf2_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    assign pool_vld   = vld_q;
    assign pool_done  = done_q;
    assign pool_dout1 = dout1_q;
    assign pool_dout2 = dout2_q;

endmodule

// File: tb/tb_ofmd_relu_pool.sv
// tb/tb_ofmd_relu_pool.sv - directed self-checking bench for ofmd_relu_pool
module tb_ofmd_relu_pool;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_st = 1'b0;
    logic          is_5x5 = 1'b0;
    logic [DW-1:0] din1 = '0;
    logic [DW-1:0] din2 = '0;
    logic          pool_vld, pool_done;
    logic [DW-1:0] pool_dout1, pool_dout2;

    ofmd_relu_pool #(.DATA_WIDTH(DW), .OFMD_W_3(6), .OFMD_W_5(4)) dut (
        .clk(clk), .rst(rst), .in_st(in_st), .is_5x5(is_5x5),
        .din1(din1), .din2(din2),
        .pool_vld(pool_vld), .pool_dout1(pool_dout1), .pool_dout2(pool_dout2),
        .pool_done(pool_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int o1[$], o2[$], od[$], oc[$], bc[$];

    always @(negedge clk) begin
        if (pool_vld) begin
            o1.push_back(int'(pool_dout1));
            o2.push_back(int'(pool_dout2));
            od.push_back(int'(pool_done));
            oc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        o1.delete(); o2.delete(); od.delete(); oc.delete(); bc.delete();
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        @(posedge clk); #1;
        in_st = 1'b1; din1 = a; din2 = b; is_5x5 = m;
        bc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_st = 1'b0;
        end
    endtask

    task automatic ramp6(input bit toggle);
        for (int i = 0; i < 36; i++) begin
            beat(DW'(i), DW'(-i), 1'b0);
            if (toggle) idle(1);
        end
    endtask

    // Window k of a 6x6 ramp completes at raster index (2*(k/3)+1)*6 + 2*(k%3)+1, which is also its max.
    task automatic check_ramp6(input string tag, input int ob, input int bb);
        int e;
        for (int kk = 0; kk < 9; kk++) begin
            e = (2 * (kk / 3) + 1) * 6 + 2 * (kk % 3) + 1;
            if (ob + kk < o1.size()) begin
                check($sformatf("%s_d1_%0d", tag, kk), o1[ob+kk], e);
                check($sformatf("%s_d2_%0d", tag, kk), o2[ob+kk], 0);
                check($sformatf("%s_done_%0d", tag, kk), od[ob+kk], (kk == 8) ? 1 : 0);
                check($sformatf("%s_lat_%0d", tag, kk), oc[ob+kk], bc[bb+e] + 1);
            end
        end
    endtask

    task automatic check_4x4(input string tag, input int e1[4], input int e2[4]);
        check({tag, "_count"}, o1.size(), 4);
        for (int kk = 0; kk < 4; kk++) begin
            if (kk < o1.size()) begin
                check($sformatf("%s_d1_%0d", tag, kk), o1[kk], e1[kk]);
                check($sformatf("%s_d2_%0d", tag, kk), o2[kk], e2[kk]);
                check($sformatf("%s_done_%0d", tag, kk), od[kk], (kk == 3) ? 1 : 0);
            end
        end
    endtask

    initial begin
        idle(2);
        check("rst_vld", pool_vld, 0);
        check("rst_done", pool_done, 0);
        check("rst_d1", pool_dout1, 0);
        check("rst_d2", pool_dout2, 0);
        rst = 1'b1;
        idle(2);

        // 6x6 ramp, continuous strobe
        clear_logs();
        ramp6(1'b0);
        idle(4);
        check("t1_count", o1.size(), 9);
        check_ramp6("t1", 0, 0);
        check("t1_hold_d1", pool_dout1, 35);
        check("t1_hold_vld", pool_vld, 0);

        // 4x4, one negative sample in window 0 on channel 1
        clear_logs();
        for (int i = 0; i < 16; i++)
            beat((i == 5) ? 16'h8000 : 16'h7fff, DW'(i), 1'b1);
        idle(4);
        check_4x4("t2", '{32'h7fff, 32'h7fff, 32'h7fff, 32'h7fff}, '{5, 7, 13, 15});
        if (oc.size() == 4) check("t2_done_lat", oc[3], bc[15] + 1);

        // 6x6 ramp, strobe toggling every cycle
        clear_logs();
        ramp6(1'b1);
        idle(4);
        check("t3_count", o1.size(), 9);
        check_ramp6("t3", 0, 0);

        // reset mid-frame after 20 beats, then a clean 4x4 frame
        clear_logs();
        for (int i = 0; i < 20; i++) beat(DW'(100 + i), DW'(200 + i), 1'b0);
        @(posedge clk); #2;
        in_st = 1'b0;
        rst = 1'b0;
        #1;
        clear_logs();
        check("t4_rst_vld", pool_vld, 0);
        check("t4_rst_d1", pool_dout1, 0);
        idle(2);
        rst = 1'b1;
        idle(3);
        check("t4_aborted_count", o1.size(), 0);
        for (int i = 0; i < 16; i++) beat(DW'(i), DW'(15 - i), 1'b1);
        idle(4);
        check_4x4("t4", '{5, 7, 13, 15}, '{15, 13, 7, 5});

        // two 6x6 frames back to back, is_5x5 raised only inside frame 1
        clear_logs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 36; i++)
                beat(DW'(i), DW'(-i), (f == 0) && (i >= 10) && (i < 30));
        idle(4);
        check("t5_count", o1.size(), 18);
        check_ramp6("t5a", 0, 0);
        check_ramp6("t5b", 9, 36);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ofmd_relu_pool.md
OFMD_RELU_POOL -- requirements
Module: ofmd_relu_pool

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of each OFMD sample; samples are two's-complement signed.
REQ-002 Parameter: OFMD_W_3, 6, OFMD edge length for the 3x3 kernel (6x6 frame).
REQ-003 Parameter: OFMD_W_5, 4, OFMD edge length for the 5x5 kernel (4x4 frame).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port: in_st  in  1  sample-valid strobe from the conv core out_st; one sample pair per high cycle.
REQ-007 Port: is_5x5  in  1  frame geometry select; 1 = 4x4 frame, 0 = 6x6 frame.
REQ-008 Port: din1  in  DATA_WIDTH  OFMD channel 1 sample (dout_ofmd1).
REQ-009 Port: din2  in  DATA_WIDTH  OFMD channel 2 sample (dout_ofmd2).
REQ-010 Port: pool_vld  out  1  pooled result valid, one-cycle pulse per output.
REQ-011 Port: pool_dout1  out  DATA_WIDTH  pooled channel 1 result.
REQ-012 Port: pool_dout2  out  DATA_WIDTH  pooled channel 2 result.
REQ-013 Port: pool_done  out  1  one-cycle pulse marking the last pooled output of a frame.

Function
REQ-014 Input stream is row-major, column fastest; frame is N x N, with N = OFMD_W_5 when is_5x5 = 1 and OFMD_W_3 otherwise.
REQ-015 Each sample is passed through ReLU: negative values (MSB = 1) become 0; non-negative values are unchanged.
REQ-016 2x2 max-pool with stride 2 is applied per channel, giving an (N/2)x(N/2) output: 3x3 for 6x6 frames, 2x2 for 4x4 frames.
REQ-017 Channels are processed independently in parallel and share counters and control.
REQ-018 FSM states are IDLE and RUN; reset enters IDLE.
REQ-019 IDLE -> RUN on the first in_st = 1 cycle; that sample is processed as (row 0, col 0).
REQ-020 is_5x5 is latched on the IDLE -> RUN cycle and held for the whole frame; changes mid-frame are ignored.
REQ-021 RUN -> IDLE on the cycle the last sample (row N-1, col N-1) is accepted.
REQ-022 Column and row counters advance only on in_st = 1.
- Column wraps from N-1 to 0 and increments row.
- Row wraps from N-1 to 0 at end of frame.
- in_st = 0 gaps of any length hold all state.
REQ-023 On even rows, the module keeps the max of the ReLU'd pair (col 2k, col 2k+1) and writes it to line-buffer entry k, which is N/2 deep per channel.
REQ-024 On odd rows, the module compares the col 2k pair max with buffer entry k; the col 2k+1 sample completes the window.
REQ-025 Registered output: on the cycle after window completion, pool_vld = 1 and pool_dout1/2 carry the 4-sample max. Latency is 1 cycle from the accepting clock edge.
REQ-026 pool_done = 1 in the same cycle as the pool_vld for output (N/2-1, N/2-1); it is 0 otherwise.
REQ-027 pool_dout1/2 hold their last value when pool_vld = 0.
REQ-028 Max comparisons are unsigned on post-ReLU values; no widening or truncation occurs, and the output width is DATA_WIDTH.
REQ-029 Ties resolve to the equal value; there is no ordering dependence.
REQ-030 There is no back-pressure: every in_st beat is consumed, and outputs are never stalled.
REQ-031 Back-to-back frames are allowed: an in_st beat in the cycle after RUN -> IDLE starts a new frame; pool_vld/pool_done from the previous frame may coincide with it.

Reset
REQ-032 While rst = 0:
- state = IDLE; row = col = 0; latched is_5x5 = 0.
- Line buffers and pair registers = 0.
- pool_vld = pool_done = 0; pool_dout1 = pool_dout2 = 0.
REQ-033 Reset takes effect asynchronously, including mid-frame; the partial frame is discarded and no pool_vld is emitted for it.
REQ-034 After rst deasserts, the next in_st beat is treated as (row 0, col 0) of a new frame.

Verification
REQ-035 6x6 frame, is_5x5 = 0, din1 = raster index 0..35, din2 = -(index), in_st held high for 36 cycles.
- Expected: 9 pool_vld pulses.
- pool_dout1 = 7, 9, 11, 19, 21, 23, 31, 33, 35.
- pool_dout2 = 0 on all 9.
- pool_done coincides with the 9th pulse, one cycle after the last beat.
REQ-036 4x4 frame, is_5x5 = 1, din1 = 16 samples all 0x7FFF except one at (1,1) = 0x8000.
- Expected: 4 outputs, all 0x7FFF.
- pool_done on the 4th output.
REQ-037 6x6 frame with in_st toggling 1/0 every cycle.
- Expected: same 9 results as REQ-035, each pool_vld one cycle after the beat that completes its window.
REQ-038 rst pulsed low after the 20th beat of a 6x6 frame, then a full 4x4 frame.
- Expected: no outputs from the aborted frame.
- Exactly 4 correct outputs from the 4x4 frame.
REQ-039 Two 6x6 frames back-to-back with no idle cycle, and is_5x5 toggled to 1 mid-frame 1.
- Expected: 18 outputs and two pool_done pulses.
- Both frames are pooled as 6x6.
